pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 64-bit enable-gated pipeline register used between fetch and decode.
- Replaces the single global `en` stall with a per-stage valid/ready handshake.
- A 2-entry skid buffer keeps `in_ready` purely registered, so back-pressure never forms a combinational path across stages.
- Adds flush (branch/exception squash) and a saturating stall-cycle counter for performance monitoring; drops in between any two pipeline stages.

Parameters:
- DATA_WIDTH, 64: payload width in bits.
- RESET_VALUE, 0: value loaded into both data registers on reset; also on flush when CLEAR_ON_FLUSH=1.
- CLEAR_ON_FLUSH, 1: 1 = flush also zeroes data registers to RESET_VALUE; 0 = flush clears valid bits only.
- STALL_CNT_WIDTH, 16: width of stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  squash all held entries this cycle.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; registered.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  payload; driven directly from main register.
- occupancy  output  2  entries held (0..2).
- clr_stats  input  1  clear stall counter.
- stall_cnt  output  STALL_CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Storage: main {m_valid, m_data}, skid {s_valid, s_data}.
  - out_valid = m_valid; out_data = m_data.
  - in_ready = ~s_valid registered as rdy_q; rdy_q=0 while reset is asserted.
- Handshakes:
  - Accept: in_valid & in_ready.
  - Emit: m_valid & out_ready.
- Reset (sync, one edge): m_valid=s_valid=0; m_data=s_data=RESET_VALUE; stall_cnt=0; occupancy=0. First cycle after reset deassertion: in_ready=1.
- Per-edge priority: reset > flush > normal.
- Flush:
  - m_valid=s_valid=0; data zeroed iff CLEAR_ON_FLUSH.
  - An accept in the same cycle is dropped.
  - in_ready=1 next cycle.
  - stall_cnt unaffected.
- Normal transitions (e = empty, M = main only, F = main+skid):
  - e, accept: m<=in_data → M.
  - M, accept & emit: m<=in_data → M (full throughput, latency 1).
  - M, emit only → e.
  - M, accept without emit: s<=in_data → F; in_ready drops next cycle.
  - F, emit: m<=s_data, s_valid=0 → M. No accept possible in F.
  - F, no emit: hold.
- Ordering: FIFO, no drop, no duplication.
- Hold rule: while out_valid & ~out_ready, out_data stays stable.
- Latency: in_data accepted at edge N appears on out_data after edge N when the stage was empty or emitting.
- Throughput: 1/cycle when out_ready held high.
- occupancy = m_valid + s_valid; s_valid=1 implies m_valid=1 (invariant).
- stall_cnt:
  - Increments each edge with out_valid & ~out_ready & ~flush.
  - Saturates at 2^STALL_CNT_WIDTH-1.
  - clr_stats forces 0, taking priority over increment.
- Data registers load only on accept/shift; no update otherwise (power).

Test Plan:
- Reset then stream 0x1..0x8 with out_ready=1 → out_data 0x1..0x8 on consecutive cycles, 1-cycle latency, occupancy ≤1, stall_cnt=0.
- Stream 0xA,0xB,0xC; drop out_ready on cycle after 0xA accepted → occupancy=2, in_ready=0 next cycle, 0xC held upstream; raise out_ready → outputs 0xA,0xB,0xC in order, none lost.
- Full stage (0x11 main, 0x22 skid), assert flush with in_valid=1 in_data=0x33 → next cycle out_valid=0, occupancy=0, out_data=0 (CLEAR_ON_FLUSH=1), 0x33 not captured.
- STALL_CNT_WIDTH=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 (saturated); pulse clr_stats → 0.
- Assert reset mid-stream at occupancy=2 → next cycle out_valid=0, in_ready=0 during reset, in_ready=1 first cycle after, out_data=RESET_VALUE.
- Random in_valid/out_ready (10k cycles, DATA_WIDTH=32) vs. scoreboard → exact in-order match, out_data stable during every stall.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready link bundle for one pipeline stage.
// slave  : the stage itself (consumes in_*, produces out_*).
// master : the environment around the stage (upstream producer and downstream consumer).
interface pipe_stage_skid_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// in_ready is a pure register, so back-pressure never crosses stages combinationally.
// Supports flush (squash) and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int                    DATA_WIDTH      = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter bit                    CLEAR_ON_FLUSH  = 1'b1,
  parameter int                    STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       clr_stats,
  output logic [1:0]                 occupancy,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
  pipe_stage_skid_if.slave           bus
);

  logic                       r_m_valid;
  logic                       r_s_valid;
  logic [DATA_WIDTH-1:0]      r_m_data;
  logic [DATA_WIDTH-1:0]      r_s_data;
  logic                       r_rdy;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  logic w_accept;
  logic w_emit;
  logic w_m_valid_nxt;
  logic w_s_valid_nxt;
  logic w_load_m_in;
  logic w_load_m_skid;
  logic w_load_s_in;

  assign w_accept = bus.in_valid & r_rdy;
  assign w_emit   = r_m_valid & bus.out_ready;

  assign bus.in_ready  = r_rdy;
  assign bus.out_valid = r_m_valid;
  assign bus.out_data  = r_m_data;
  assign occupancy     = {1'b0, r_m_valid} + {1'b0, r_s_valid};
  assign stall_cnt     = r_stall_cnt;

  // Next-state and load enables for the empty / main-only / main+skid occupancy cases.
  always_comb begin
    w_m_valid_nxt = r_m_valid;
    w_s_valid_nxt = r_s_valid;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s_in   = 1'b0;
    if (!r_m_valid) begin
      if (w_accept) begin
        w_m_valid_nxt = 1'b1;
        w_load_m_in   = 1'b1;
      end
    end else if (!r_s_valid) begin
      if (w_accept && w_emit) begin
        w_load_m_in = 1'b1;
      end else if (w_emit) begin
        w_m_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_s_valid_nxt = 1'b1;
        w_load_s_in   = 1'b1;
      end
    end else if (w_emit) begin
      // Skid full: in_ready is low, so only a shift from skid to main can occur.
      w_s_valid_nxt = 1'b0;
      w_load_m_skid = 1'b1;
    end
  end

  // Valid bits and registered in_ready; reset > flush > normal.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_rdy     <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_rdy     <= 1'b1;
    end else begin
      r_m_valid <= w_m_valid_nxt;
      r_s_valid <= w_s_valid_nxt;
      r_rdy     <= ~w_s_valid_nxt;
    end
  end

  // Payload registers load only on accept or skid shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_data <= RESET_VALUE;
      r_s_data <= RESET_VALUE;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        r_m_data <= RESET_VALUE;
        r_s_data <= RESET_VALUE;
      end
    end else begin
      if (w_load_m_in) begin
        r_m_data <= bus.in_data;
      end else if (w_load_m_skid) begin
        r_m_data <= r_s_data;
      end
      if (w_load_s_in) begin
        r_s_data <= bus.in_data;
      end
    end
  end

  // Saturating count of cycles where output is valid but not taken.
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      r_stall_cnt <= '0;
    end else if (r_m_valid && !bus.out_ready && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic,
// compared against a queue-based model of the stage contents.
module tb_pipe_stage_skid;

  localparam int              DW        = 32;
  localparam int              SW        = 4;
  localparam logic [DW-1:0]   RV        = 32'hC0DE_0000;
  localparam int              STALL_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          clr_stats;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  pipe_stage_skid_if #(.DATA_WIDTH(DW)) bus ();

  pipe_stage_skid #(
    .DATA_WIDTH     (DW),
    .RESET_VALUE    (RV),
    .CLEAR_ON_FLUSH (1'b1),
    .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .clr_stats(clr_stats),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the entries held by the stage in FIFO order, plus the visible side state.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last;
  bit            m_rdy;
  int            m_stall;
  bit            known = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare_outputs();
    if (known) begin
      check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      check("out_data",  64'(bus.out_data),  64'((mq.size() != 0) ? mq[0] : m_last));
      check("in_ready",  64'(bus.in_ready),  64'(m_rdy));
      check("occupancy", 64'(occupancy),     64'(mq.size()));
      check("stall_cnt", 64'(stall_cnt),     64'(m_stall));
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (reset) begin
      mq.delete();
      m_rdy   = 1'b0;
      m_stall = 0;
      m_last  = RV;
      known   = 1'b1;
    end else if (known) begin
      if (clr_stats) m_stall = 0;
      else if (mq.size() > 0 && !bus.out_ready && !flush && m_stall < STALL_MAX) m_stall++;
      if (flush) begin
        mq.delete();
        m_last = RV;
        m_rdy  = 1'b1;
      end else begin
        acc = bus.in_valid && m_rdy;
        if (mq.size() > 0 && bus.out_ready) m_last = mq.pop_front();
        if (acc) mq.push_back(bus.in_data);
        m_rdy = (mq.size() < 2);
      end
    end
  endtask

  task automatic cycle(input bit iv, input logic [DW-1:0] id, input bit ordy,
                       input bit fl, input bit clr, input bit rst);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    flush         = fl;
    clr_stats     = clr;
    reset         = rst;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    clr_stats     = 1'b0;
    reset         = 1'b1;
    #1;

    // Reset held for two edges; in_ready stays low while reset is asserted.
    cycle(0, '0, 1, 0, 0, 1);
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(RV));
    cycle(0, '0, 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 0);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) cycle(1, DW'(i), 1, 0, 0, 0);
    check("stream_last", 64'(bus.out_data), 64'(8));
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // Back-pressure fills the skid; 0xC waits upstream.
    cycle(1, 32'hA, 1, 0, 0, 0);
    cycle(1, 32'hB, 0, 0, 0, 0);
    check("bp_occupancy", 64'(occupancy), 64'(2));
    check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    cycle(1, 32'hC, 0, 0, 0, 0);
    cycle(1, 32'hC, 1, 0, 0, 0);
    cycle(1, 32'hC, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // Flush of a full stage drops the simultaneous input.
    cycle(1, 32'h11, 0, 0, 0, 0);
    cycle(1, 32'h22, 0, 0, 0, 0);
    cycle(1, 32'h33, 0, 1, 0, 0);
    check("flush_out_valid", 64'(bus.out_valid), 64'(0));
    check("flush_occupancy", 64'(occupancy), 64'(0));
    check("flush_out_data", 64'(bus.out_data), 64'(RV));
    check("flush_in_ready", 64'(bus.in_ready), 64'(1));
    cycle(0, '0, 1, 0, 0, 0);

    // Stall counter saturation and clear.
    cycle(1, 32'h55, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, '0, 0, 0, 0, 0);
    check("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
    cycle(0, '0, 0, 0, 1, 0);
    check("stall_clr", 64'(stall_cnt), 64'(0));
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // Reset while full.
    cycle(1, 32'h66, 0, 0, 0, 0);
    cycle(1, 32'h77, 0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0, 1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    check("midrst_out_data", 64'(bus.out_data), 64'(RV));
    cycle(0, '0, 0, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 0);
    check("midrst_rdy_after", 64'(bus.in_ready), 64'(1));

    // Random traffic with occasional flush, clear and reset.
    for (int i = 0; i < 10000; i++) begin
      int  phase;
      bit  iv, ordy, fl, clr, rst;
      phase = (i / 1000) % 3;
      iv    = ($urandom % 4) != 0;
      case (phase)
        0:       ordy = ($urandom % 4) != 0;
        1:       ordy = ($urandom % 2) != 0;
        default: ordy = ($urandom % 4) == 0;
      endcase
      fl  = ($urandom % 64) == 0;
      clr = ($urandom % 50) == 0;
      rst = ($urandom % 700) == 0;
      cycle(iv, DW'($urandom), ordy, fl, clr, rst);
    end
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    check("drain_occupancy", 64'(occupancy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
